mem_port_arbiter: RTL and testbench

//   Round-robin arbiter sharing one memory/resource port among 4 requesters.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 19 +
 rtl/mem_port_arbiter_rr_pick4.sv | 26 ++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing for the memory-port arbiter and the bus mux it steers.
package mem_port_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    localparam int ARB_N_REQ = 4;
    localparam int ARB_SEL_W = 2;

    function automatic logic [ARB_N_REQ-1:0] sel_to_onehot(input logic [ARB_SEL_W-1:0] s);
        return ARB_N_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle between the requesters and the memory-port arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [ARB_N_REQ-1:0] req;
    logic                 done;
    logic [ARB_SEL_W-1:0] sel;
    logic [ARB_N_REQ-1:0] grant;
    logic                 start;
    logic                 busy;
    logic                 timeout;

    modport master (output req, output done,
                    input sel, input grant, input start, input busy, input timeout);

    modport slave  (input req, input done,
                    output sel, output grant, output start, output busy, output timeout);

endinterface

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Round-robin winner selection: rotate so ptr lands on bit 0, pick lowest set bit, un-rotate.
module rr_pick4
    import mem_port_arbiter_pkg::*;
(
    input  logic [ARB_N_REQ-1:0] req,
    input  logic [ARB_SEL_W-1:0] ptr,
    output logic                 valid,
    output logic [ARB_SEL_W-1:0] idx
);

    logic [ARB_N_REQ-1:0] rot;
    logic [ARB_SEL_W-1:0] pos;

    assign rot   = ARB_N_REQ'({req, req} >> ptr);
    assign valid = |rot;

    always_comb begin
        pos = '0;
        for (int i = ARB_N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = ARB_SEL_W'(i);
        end
    end

    assign idx = pos + ptr;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a shared memory port: holds one requester's grant until done or timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
)(
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t           state_q, state_d;
    logic [ARB_SEL_W-1:0] ptr_q, ptr_d;
    logic [ARB_SEL_W-1:0] sel_q, sel_d;
    logic [ARB_N_REQ-1:0] grant_q, grant_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_c;
    logic                 pick_valid;
    logic [ARB_SEL_W-1:0] pick_idx;
    logic                 to_hit;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // timeout is decoded from registered state but must yield to a same-cycle done
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_OWN;
                    sel_d   = pick_idx;
                    grant_d = sel_to_onehot(pick_idx);
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ARB_OWN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.done || to_hit) begin
                    timeout_c = !bus.done;
                    state_d   = ARB_IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + ARB_SEL_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.grant   = grant_q;
    assign bus.start   = start_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_c;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));
    a_busy_grant:   assert property (@(posedge clk) disable iff (!reset_n) busy_q == |grant_q);
    a_grant_sel:    assert property (@(posedge clk) disable iff (!reset_n) (grant_q != '0) |-> grant_q[sel_q]);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for the round-robin memory-port arbiter.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   check_count = 0;
    int   pass_count  = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic done);
        bus.req  = req;
        bus.done = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};

        reset_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        #3;
        checkOutput("rst_sel",     32'(bus.sel),     32'd0);
        checkOutput("rst_grant",   32'(bus.grant),   32'd0);
        checkOutput("rst_start",   32'(bus.start),   32'd0);
        checkOutput("rst_busy",    32'(bus.busy),    32'd0);
        checkOutput("rst_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Single requester, done three cycles after start, then re-grant after one idle cycle
        applyStimulus(4'b0001, 1'b0);
        step();
        checkOutput("single_grant", 32'(bus.grant), 32'b0001);
        checkOutput("single_sel",   32'(bus.sel),   32'd0);
        checkOutput("single_start", 32'(bus.start), 32'd1);
        checkOutput("single_busy",  32'(bus.busy),  32'd1);
        step();
        checkOutput("single_start_low", 32'(bus.start), 32'd0);
        checkOutput("single_hold1",     32'(bus.grant), 32'b0001);
        step();
        checkOutput("single_hold2", 32'(bus.grant), 32'b0001);
        step();
        applyStimulus(4'b0001, 1'b1);
        checkOutput("single_hold3", 32'(bus.grant), 32'b0001);
        step();
        applyStimulus(4'b0001, 1'b0);
        checkOutput("single_idle_grant", 32'(bus.grant), 32'd0);
        checkOutput("single_idle_busy",  32'(bus.busy),  32'd0);
        checkOutput("single_idle_sel",   32'(bus.sel),   32'd0);
        step();
        checkOutput("single_regrant", 32'(bus.grant), 32'b0001);
        checkOutput("single_restart", 32'(bus.start), 32'd1);
        applyStimulus(4'b0000, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("done_with_start", 32'(bus.grant), 32'd0);

        // Move ptr to 2, then scan order 2,3,0 picks requester 0
        applyStimulus(4'b0010, 1'b0);
        step();
        checkOutput("ptr1_pick1", 32'(bus.grant), 32'b0010);
        applyStimulus(4'b0000, 1'b1);
        step();
        applyStimulus(4'b0011, 1'b0);
        step();
        checkOutput("ptr2_scan", 32'(bus.grant), 32'b0001);
        checkOutput("ptr2_sel",  32'(bus.sel),   32'd0);
        applyStimulus(4'b0010, 1'b1);
        step();
        applyStimulus(4'b0010, 1'b0);
        checkOutput("ptr2_release", 32'(bus.grant), 32'd0);
        step();
        checkOutput("ptr1_again", 32'(bus.grant), 32'b0010);
        applyStimulus(4'b0000, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0);

        // done while idle is ignored; dropping req mid-ownership keeps the grant
        applyStimulus(4'b0000, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("idle_done_grant", 32'(bus.grant), 32'd0);
        checkOutput("idle_done_busy",  32'(bus.busy),  32'd0);
        checkOutput("idle_done_start", 32'(bus.start), 32'd0);
        applyStimulus(4'b0100, 1'b0);
        step();
        checkOutput("own2_grant", 32'(bus.grant), 32'b0100);
        applyStimulus(4'b0000, 1'b0);
        step();
        step();
        checkOutput("req_drop_hold", 32'(bus.grant), 32'b0100);
        checkOutput("req_drop_busy", 32'(bus.busy),  32'd1);

        // Asynchronous reset in the middle of an ownership
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_grant", 32'(bus.grant), 32'd0);
        checkOutput("async_rst_busy",  32'(bus.busy),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        applyStimulus(4'b1010, 1'b0);
        step();
        checkOutput("post_rst_grant", 32'(bus.grant), 32'b0010);
        checkOutput("post_rst_sel",   32'(bus.sel),   32'd1);
        applyStimulus(4'b0000, 1'b1);
        step();
        applyStimulus(4'b0000, 1'b0);

        // Timeout: requester 3 never sees done, forced release at cnt 15
        applyStimulus(4'b1000, 1'b0);
        step();
        checkOutput("to_grant", 32'(bus.grant), 32'b1000);
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 15; k++) begin
            checkOutput("to_quiet", 32'(bus.timeout), 32'd0);
            step();
        end
        checkOutput("to_pulse",      32'(bus.timeout), 32'd1);
        checkOutput("to_pulse_hold", 32'(bus.grant),   32'b1000);
        step();
        checkOutput("to_after_pulse", 32'(bus.timeout), 32'd0);
        checkOutput("to_after_grant", 32'(bus.grant),   32'd0);
        checkOutput("to_after_busy",  32'(bus.busy),    32'd0);
        checkOutput("to_after_sel",   32'(bus.sel),     32'd3);

        // All four requesting: rotation starts at 0 because ptr wrapped 3->0
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("rr_sel",   32'(bus.sel),   32'(exp_seq[i]));
            checkOutput("rr_grant", 32'(bus.grant), 32'(1) << exp_seq[i]);
            checkOutput("rr_start", 32'(bus.start), 32'd1);
            step();
            applyStimulus(4'b1111, 1'b1);
            checkOutput("rr_start_once", 32'(bus.start), 32'd0);
            step();
            applyStimulus(4'b1111, 1'b0);
            checkOutput("rr_idle", 32'(bus.grant), 32'd0);
        end
        applyStimulus(4'b0000, 1'b0);

        // done coinciding with the timeout cycle wins; no timeout pulse
        applyStimulus(4'b0100, 1'b0);
        step();
        checkOutput("coinc_grant", 32'(bus.grant), 32'b0100);
        applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 15; k++) step();
        applyStimulus(4'b0000, 1'b1);
        #1;
        checkOutput("coinc_no_timeout", 32'(bus.timeout), 32'd0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("coinc_release", 32'(bus.grant), 32'd0);
        checkOutput("coinc_busy",    32'(bus.busy),  32'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
